sysarr_in_feeder: RTL

- Input-side counterpart of the systolic array's output FIFO: accepts whole rows of N operands in parallel over a valid/ready handshake.
- Buffers rows in a small FIFO and drives them into the array's left-edge inputs with diagonal skew: lane i is delayed i cycles relative to lane 0.
- Sits between the operand load path (scratchpad/DMA side) and the systolic array row inputs.
- Per-lane valid bits let the array distinguish data from bubbles.

---
 rtl/sysarr_pkg.sv | 13 +
 rtl/sysarr_skew_lane.sv | 40 ++++
 rtl/sysarr_in_feeder.sv | 95 +++++++++
 3 files changed

// File: rtl/sysarr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sysarr_pkg : shared defaults and operand type for the systolic array edge.  |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
package sysarr_pkg;
  localparam int SYSARR_N     = 4;
  localparam int SYSARR_WIDTH = 16;
  localparam int SYSARR_DEPTH = 2;

  typedef logic [SYSARR_WIDTH-1:0] operand_t;
endpackage : sysarr_pkg
`default_nettype wire

// File: rtl/sysarr_skew_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sysarr_skew_lane : DELAY-stage data+valid shift chain, advances on en.      |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module sysarr_skew_lane #(
  parameter int DELAY = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             any_valid
);
  logic [WIDTH-1:0] data_q  [DELAY];
  logic [DELAY-1:0] valid_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < DELAY; k++) data_q[k] <= '0;
      valid_q <= '0;
    end else if (en) begin
      data_q[0]  <= d;
      valid_q[0] <= d_valid;
      for (int k = 1; k < DELAY; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  assign q         = data_q[DELAY-1];
  assign q_valid   = valid_q[DELAY-1];
  assign any_valid = |valid_q;
endmodule : sysarr_skew_lane
`default_nettype wire

// File: rtl/sysarr_in_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sysarr_in_feeder : row FIFO feeding the array left edge with diagonal skew. |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module sysarr_in_feeder
  import sysarr_pkg::*;
#(
  parameter int N     = SYSARR_N,
  parameter int WIDTH = SYSARR_WIDTH,
  parameter int DEPTH = SYSARR_DEPTH
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*N-1:0]         in_row,
  input  logic                       array_en,
  output logic [N-1:0]               out_valid,
  output logic [WIDTH*N-1:0]         out_data,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH*N-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               w_push, w_pop;
  logic [WIDTH*N-1:0] w_head;
  logic [N-1:0]       w_lane_busy;

  // Readiness depends only on registered occupancy, so a full buffer never
  // accepts a row even in a cycle where it also pops.
  assign in_ready = (count_q < C_DEPTH);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = array_en && (count_q != '0);
  assign w_head   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= in_row;
  end

  // A cycle with array_en high and nothing buffered injects a bubble.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WIDTH-1:0] w_d;
    assign w_d = w_pop ? w_head[WIDTH*i +: WIDTH] : '0;

    sysarr_skew_lane #(
      .DELAY (i + 1),
      .WIDTH (WIDTH)
    ) u_lane (
      .clk       (clk),
      .nRST      (nRST),
      .en        (array_en),
      .d         (w_d),
      .d_valid   (w_pop),
      .q         (out_data[WIDTH*i +: WIDTH]),
      .q_valid   (out_valid[i]),
      .any_valid (w_lane_busy[i])
    );
  end

  assign busy  = (count_q != '0) || (|w_lane_busy);
  assign count = count_q;
endmodule : sysarr_in_feeder
`default_nettype wire
